// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder that feeds an external 4-bit adder one nibble per cycle.
// The carry between nibbles is chained through carry_r.
module nibble_serial_adder #(
  parameter int WIDTH = 16  // multiple of 4, at least 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             op_cin,
  output logic [3:0]       add_a,
  output logic [3:0]       add_b,
  output logic             add_cin,
  input  logic [3:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_cout,
  output logic             overflow
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W   = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t state, state_nx;
  logic [IDX_W-1:0] idx;
  logic carry_r;
  logic [NIBBLES-1:0][3:0] a_r, b_r, res_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    add_a     = 4'd0;
    add_b     = 4'd0;
    add_cin   = 1'b0;
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    case (state)
      IDLE: if (in_valid) state_nx = RUN;
      RUN: begin
        add_a   = a_r[idx];
        add_b   = b_r[idx];
        add_cin = carry_r;
        if (idx == LAST_IDX) state_nx = DONE;
      end
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Unwritten result nibbles keep the previous operation's values until overwritten
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx         <= '0;
      carry_r     <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      res_r       <= '0;
      result_cout <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          a_r     <= op_a;
          b_r     <= op_b;
          carry_r <= op_cin;
          idx     <= '0;
        end
        RUN: begin
          res_r[idx] <= add_sum;
          carry_r    <= add_cout;
          if (idx == LAST_IDX) begin
            result_cout <= add_cout;
            overflow    <= (a_r[NIBBLES-1][3] == b_r[NIBBLES-1][3]) &
                           (add_sum[3] != a_r[NIBBLES-1][3]);
            idx         <= '0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign result = res_r;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder with a behavioural 4-bit adder on the add_* ports.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] op_a = '0;
  logic [WIDTH-1:0] op_b = '0;
  logic             op_cin = 1'b0;
  logic [3:0]       add_a, add_b, add_sum;
  logic             add_cin, add_cout;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] result;
  logic             result_cout, overflow;

  int vectors = 0;
  int miscompares = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_a(op_a), .op_b(op_b), .op_cin(op_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .result_cout(result_cout), .overflow(overflow)
  );

  // The external 4-bit ripple-carry adder, purely combinational
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'd0, add_cin};

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                               input logic cin);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("accept_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    op_a     = a;
    op_b     = b;
    op_cin   = cin;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Called #1 after the accept edge; leaves the DUT in DONE
  task automatic checkRun(input string tag, input logic [WIDTH-1:0] exp_res,
                          input logic exp_cout, input logic exp_ovf,
                          input logic [3:0] exp_trace);
    logic [3:0] trace;
    trace = '0;
    for (int i = 0; i < 4; i++) begin
      trace[i] = add_cin;
      if (i == 3) checkOutput({tag, "_early_valid"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
    end
    checkOutput({tag, "_valid"},    32'(out_valid),   32'd1);
    checkOutput({tag, "_result"},   32'(result),      32'(exp_res));
    checkOutput({tag, "_cout"},     32'(result_cout), 32'(exp_cout));
    checkOutput({tag, "_overflow"}, 32'(overflow),    32'(exp_ovf));
    checkOutput({tag, "_cin_trace"}, 32'(trace),      32'(exp_trace));
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_in_ready",  32'(in_ready),    32'd1);
    checkOutput("rst_out_valid", 32'(out_valid),   32'd0);
    checkOutput("rst_result",    32'(result),      32'd0);
    checkOutput("rst_cout",      32'(result_cout), 32'd0);
    checkOutput("rst_overflow",  32'(overflow),    32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Trace bit i is add_cin during RUN cycle i
    applyStimulus(16'h1234, 16'h4321, 1'b0);
    checkRun("basic", 16'h5555, 1'b0, 1'b0, 4'b0000);
    releaseResult();

    applyStimulus(16'hFFFF, 16'h0001, 1'b0);
    checkRun("ripple", 16'h0000, 1'b1, 1'b0, 4'b1110);
    releaseResult();

    applyStimulus(16'h7FFF, 16'h0001, 1'b0);
    checkRun("ovf_pos", 16'h8000, 1'b0, 1'b1, 4'b1110);
    releaseResult();

    applyStimulus(16'h8000, 16'h8000, 1'b0);
    checkRun("ovf_neg", 16'h0000, 1'b1, 1'b1, 4'b0000);
    releaseResult();

    applyStimulus(16'h00FF, 16'h0000, 1'b1);
    checkRun("cin", 16'h0100, 1'b0, 1'b0, 4'b0111);

    // Back-pressure: DONE held while new operands are offered
    in_valid = 1'b1;
    op_a     = 16'h1111;
    op_b     = 16'h2222;
    op_cin   = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_result",   32'(result),    32'h0100);
      checkOutput("bp_in_ready", 32'(in_ready),  32'd0);
      checkOutput("bp_valid",    32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("bp_idle_ready", 32'(in_ready),  32'd1);
    checkOutput("bp_idle_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checkOutput("bp_taken", 32'(in_ready), 32'd0);
    checkRun("bp_new", 16'h3333, 1'b0, 1'b0, 4'b0000);
    releaseResult();

    // Reset after two nibbles have been processed
    applyStimulus(16'hAAAA, 16'h5555, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_result",   32'(result),      32'd0);
    checkOutput("mid_rst_valid",    32'(out_valid),   32'd0);
    checkOutput("mid_rst_cout",     32'(result_cout), 32'd0);
    checkOutput("mid_rst_overflow", 32'(overflow),    32'd0);
    checkOutput("mid_rst_add_a",    32'(add_a),       32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("mid_rst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("mid_rst_no_valid", 32'(out_valid), 32'd0);

    applyStimulus(16'h0F0F, 16'h00F1, 1'b0);
    checkRun("post_rst", 16'h1000, 1'b0, 1'b0, 4'b1110);
    releaseResult();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
